riscv_mem_sched: RTL and testbench
==================================

Name: riscv_mem_sched

Overview:
- Sequences all memory traffic of the RISC-V core onto one shared single-port memory.
- Arbitrates between the instruction-fetch port and the load/store port.
- Breaks byte/halfword stores into read-modify-write (RMW) pairs and checks alignment.
- Sits between the core and the unified instruction/data RAM.

Parameters:
ADDR_W, 32, byte-address width
DATA_W, 32, memory word width (fixed 32; lane logic assumes 4 bytes)
MEM_LAT, 1, cycles from the edge sampling mem_en to mem_rdata valid (1..4)

Ports:
clk  in  1  clock
rst_n  in  1  reset
if_req  in  1  fetch request; held with if_addr until if_done
if_addr  in  ADDR_W  fetch byte address (low 2 bits ignored)
if_rdata  out  DATA_W  fetched word, valid while if_done=1
if_done  out  1  one-cycle fetch completion pulse
ls_req  in  1  load/store request; held with fields until ls_done
ls_we  in  1  1=store, 0=load
ls_size  in  2  00 byte, 01 half, 10 word, 11 illegal
ls_signed  in  1  loads: sign-extend (1) / zero-extend (0)
ls_addr  in  ADDR_W  byte address
ls_wdata  in  DATA_W  store data, right-aligned
ls_rdata  out  DATA_W  extended load data, valid while ls_done=1
ls_done  out  1  one-cycle completion pulse
ls_err  out  1  with ls_done: misaligned or illegal size, no memory access made
mem_en  out  1  memory strobe, one cycle per access
mem_rw  out  1  1=write, 0=read
mem_addr  out  ADDR_W  word-aligned address {addr[31:2],2'b00}
mem_wdata  out  DATA_W  write word
mem_rdata  in  DATA_W  read word
busy  out  1  FSM not in IDLE

Behaviour:
- Clock and reset: one clock, clk. rst_n is asynchronous, active-low.
- On reset:
  - All outputs go to 0 and the FSM goes to IDLE.
  - last_grant is set to IF.
  - Reset mid-access aborts the access; no done pulse is issued after release.
- States: IDLE, RD_ISSUE, RD_WAIT, WR_ISSUE, RESP.
- IDLE arbitration:
  - Only one requester → grant it.
  - Both requesting → grant the one not equal to last_grant, so they alternate. First conflict after reset goes to LS.
  - last_grant updates on each grant.
- LS checks at grant:
  - size=11, half with addr[0]=1, or word with addr[1:0]!=0 → RESP with ls_err=1, ls_rdata=0, mem_en never asserted.
- Grant routing:
  - Fetch, load, or byte/half store → RD_ISSUE.
  - Word store → WR_ISSUE.
- RD_ISSUE:
  - mem_en=1, mem_rw=0 for exactly one cycle, then RD_WAIT.
- RD_WAIT:
  - Counts MEM_LAT cycles, then captures mem_rdata into an internal word register.
  - Fetch/load → RESP. Byte/half store → WR_ISSUE (merge).
- WR_ISSUE:
  - mem_en=1, mem_rw=1 for one cycle, then RESP.
  - mem_wdata is ls_wdata for a word store.
  - For byte/half stores, mem_wdata is the captured word with the lane replaced: byte lane addr[1:0] gets ls_wdata[7:0]; half lane addr[1] gets ls_wdata[15:0].
- RESP:
  - Exactly one of if_done/ls_done is 1 for one cycle, with the rdata output valid.
  - Then return to IDLE. Requests are ignored in RESP.
  - Requesters drop req after seeing done; req still high in IDLE is a new request.
- Load extraction: select byte/half by addr[1:0]/addr[1], then extend per ls_signed. Word loads pass through unchanged.
- mem_en is 0 in every state other than RD_ISSUE and WR_ISSUE. mem_addr/mem_wdata hold their value until the next issue.
- Latency, counted from the grant edge to the done cycle:
  - fetch/load: MEM_LAT+2
  - word store: 2
  - byte/half store: MEM_LAT+3
  - error: 1
- A request arriving during busy waits. Both ports can have at most one outstanding request.
- if_rdata/ls_rdata are 0 outside their done cycle.

Test Plan:
- Reset with rst_n=0 mid-RD_WAIT → all outputs 0 immediately; after release, no done pulse; next if_req to 0x100 completes with if_rdata=mem[0x100].
- MEM_LAT=1: if_req to 0x40, mem word 0xDEADBEEF → one mem_en read at 0x40, if_done with 0xDEADBEEF at grant+3 cycles.
- Load byte, ls_signed=1, addr 0x103, word 0x80FF1234 → ls_rdata=0xFFFFFF80. Same access with ls_signed=0 → 0x00000080.
- Store half 0xABCD at 0x202, mem word 0x11223344 → read then write 0xABCD3344 at 0x200; exactly two mem_en cycles; ls_done at grant+4.
- Store word at 0x105 → ls_done=1, ls_err=1 at grant+1; mem_en stays 0 throughout.
- if_req and ls_req held continuously from reset → grant order LS, IF, LS, IF; no request starved, each done pulse one cycle.

Source files
------------

// File: rtl/riscv_mem_sched_if.sv
// Core-side fetch/load-store handshakes and the shared memory port of riscv_mem_sched.
// slave is the scheduler's view; master is the core + RAM side.
interface riscv_mem_sched_if #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
);
  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic [DATA_W-1:0] if_rdata;
  logic              if_done;

  logic              ls_req;
  logic              ls_we;
  logic [1:0]        ls_size;
  logic              ls_signed;
  logic [ADDR_W-1:0] ls_addr;
  logic [DATA_W-1:0] ls_wdata;
  logic [DATA_W-1:0] ls_rdata;
  logic              ls_done;
  logic              ls_err;

  logic              mem_en;
  logic              mem_rw;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  logic              busy;

  modport slave (
    input  if_req, if_addr, ls_req, ls_we, ls_size, ls_signed, ls_addr, ls_wdata, mem_rdata,
    output if_rdata, if_done, ls_rdata, ls_done, ls_err, mem_en, mem_rw, mem_addr, mem_wdata, busy
  );

  modport master (
    output if_req, if_addr, ls_req, ls_we, ls_size, ls_signed, ls_addr, ls_wdata, mem_rdata,
    input  if_rdata, if_done, ls_rdata, ls_done, ls_err, mem_en, mem_rw, mem_addr, mem_wdata, busy
  );
endinterface

// File: rtl/riscv_mem_sched.sv
// Shares one single-port RAM between instruction fetch and load/store, alternating on
// conflict; sub-word stores become read-modify-write pairs, misaligned accesses error out.
module riscv_mem_sched #(
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned MEM_LAT = 1
) (
  input logic              clk,
  input logic              rst_n,
  riscv_mem_sched_if.slave bus
);

  typedef enum logic [2:0] {IDLE, RD_ISSUE, RD_WAIT, WR_ISSUE, RESP} state_t;
  typedef enum logic {G_IF, G_LS} grant_t;

  localparam logic [2:0] WAIT_LAST = 3'(MEM_LAT - 1);

  state_t            state_q, state_d;
  grant_t            last_grant_q, owner_q, grant_d;
  logic              err_q;
  logic [2:0]        cnt_q;
  logic [DATA_W-1:0] word_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;

  logic              pick_ls, ls_bad, ls_word_st, wait_done;
  logic [DATA_W-1:0] merged, ld_ext;
  logic [7:0]        ld_byte;
  logic [15:0]       ld_half;

  // On conflict the port that did not win last time gets the grant.
  assign pick_ls    = bus.ls_req && (!bus.if_req || last_grant_q == G_IF);
  assign grant_d    = pick_ls ? G_LS : G_IF;
  assign ls_bad     = (bus.ls_size == 2'b11) ||
                      (bus.ls_size == 2'b01 && bus.ls_addr[0]) ||
                      (bus.ls_size == 2'b10 && bus.ls_addr[1:0] != 2'b00);
  assign ls_word_st = bus.ls_we && bus.ls_size == 2'b10;
  assign wait_done  = cnt_q == WAIT_LAST;

  always_comb begin
    merged = bus.mem_rdata;
    if (bus.ls_size == 2'b00)
      merged[{bus.ls_addr[1:0], 3'b000} +: 8] = bus.ls_wdata[7:0];
    else
      merged[{bus.ls_addr[1], 4'b0000} +: 16] = bus.ls_wdata[15:0];
  end

  always_comb begin
    ld_byte = word_q[{bus.ls_addr[1:0], 3'b000} +: 8];
    ld_half = word_q[{bus.ls_addr[1], 4'b0000} +: 16];
    unique case (bus.ls_size)
      2'b00:   ld_ext = {{(DATA_W-8){bus.ls_signed & ld_byte[7]}}, ld_byte};
      2'b01:   ld_ext = {{(DATA_W-16){bus.ls_signed & ld_half[15]}}, ld_half};
      default: ld_ext = word_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (pick_ls) begin
          if (ls_bad)          state_d = RESP;
          else if (ls_word_st) state_d = WR_ISSUE;
          else                 state_d = RD_ISSUE;
        end else if (bus.if_req) begin
          state_d = RD_ISSUE;
        end
      end
      RD_ISSUE: state_d = RD_WAIT;
      RD_WAIT:  if (wait_done) state_d = (owner_q == G_LS && bus.ls_we) ? WR_ISSUE : RESP;
      WR_ISSUE: state_d = RESP;
      RESP:     state_d = IDLE;
      default:  state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_grant_q <= G_IF;
      owner_q      <= G_IF;
      err_q        <= 1'b0;
      cnt_q        <= '0;
      word_q       <= '0;
      addr_q       <= '0;
      wdata_q      <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (bus.if_req || bus.ls_req) begin
            owner_q      <= grant_d;
            last_grant_q <= grant_d;
            err_q        <= pick_ls && ls_bad;
            cnt_q        <= '0;
            // Rejected accesses leave the memory bus untouched.
            if (!(pick_ls && ls_bad))
              addr_q <= (pick_ls ? bus.ls_addr : bus.if_addr) & ~ADDR_W'(3);
            if (pick_ls && ls_word_st)
              wdata_q <= bus.ls_wdata;
          end
        end
        RD_WAIT: begin
          cnt_q <= cnt_q + 3'd1;
          if (wait_done) begin
            word_q <= bus.mem_rdata;
            if (owner_q == G_LS && bus.ls_we) wdata_q <= merged;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    bus.mem_en    = state_q == RD_ISSUE || state_q == WR_ISSUE;
    bus.mem_rw    = state_q == WR_ISSUE;
    bus.mem_addr  = addr_q;
    bus.mem_wdata = wdata_q;
    bus.busy      = state_q != IDLE;
    bus.if_done   = state_q == RESP && owner_q == G_IF;
    bus.ls_done   = state_q == RESP && owner_q == G_LS;
    bus.ls_err    = bus.ls_done && err_q;
    bus.if_rdata  = bus.if_done ? word_q : '0;
    bus.ls_rdata  = (bus.ls_done && !err_q && !bus.ls_we) ? ld_ext : '0;
  end

endmodule

// File: tb/tb_riscv_mem_sched.sv
// Randomized and directed bench for riscv_mem_sched against a word-array memory model
// and mask/shift reference arithmetic for loads, stores, latency and arbitration.
module tb_riscv_mem_sched;
  localparam int unsigned MEM_LAT = 1;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  riscv_mem_sched_if #(.ADDR_W(32), .DATA_W(32)) bus ();

  riscv_mem_sched #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(MEM_LAT)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;

  function automatic logic [31:0] mem_init(input int unsigned idx);
    case (idx)
      32'h10:  return 32'hDEADBEEF;
      32'h40:  return 32'h80FF1234;
      32'h80:  return 32'h11223344;
      default: return (idx * 32'h9E3779B1) ^ 32'h5A5A0000;
    endcase
  endfunction

  // RAM model: 256 words, read data appears MEM_LAT cycles behind the sampled strobe.
  logic [31:0]  ram [256];
  logic [255:0] ram_wr = '0;
  logic [31:0]  pipe [MEM_LAT];
  int           en_cnt = 0;
  logic [31:0]  last_wr_addr = '0;
  logic [31:0]  last_rd_addr = '0;
  logic [31:0]  ref_mem [256];

  always @(posedge clk) begin
    if (bus.mem_en) begin
      en_cnt <= en_cnt + 1;
      if (bus.mem_rw) begin
        ram[bus.mem_addr[9:2]]    <= bus.mem_wdata;
        ram_wr[bus.mem_addr[9:2]] <= 1'b1;
        last_wr_addr              <= bus.mem_addr;
      end else begin
        pipe[0]      <= ram_wr[bus.mem_addr[9:2]] ? ram[bus.mem_addr[9:2]] : mem_init(32'(bus.mem_addr[9:2]));
        last_rd_addr <= bus.mem_addr;
      end
    end
    for (int i = 1; i < int'(MEM_LAT); i++) pipe[i] <= pipe[i-1];
  end
  assign bus.mem_rdata = pipe[MEM_LAT-1];

  function automatic logic [31:0] ram_word(input logic [31:0] a);
    return ram_wr[a[9:2]] ? ram[a[9:2]] : mem_init(32'(a[9:2]));
  endfunction

  function automatic logic [31:0] model_load(input logic [31:0] w, input int size, input bit sgn,
                                             input logic [31:0] a);
    int unsigned off;
    logic [31:0] v;
    off = a % 4;
    if (size == 2) return w;
    if (size == 0) begin
      v = (w >> (8 * off)) & 32'hFF;
      if (sgn && v >= 32'h80) v = v + 32'hFFFFFF00;
    end else begin
      v = (w >> (16 * (off / 2))) & 32'hFFFF;
      if (sgn && v >= 32'h8000) v = v + 32'hFFFF0000;
    end
    return v;
  endfunction

  function automatic logic [31:0] model_store(input logic [31:0] w, input int size,
                                              input logic [31:0] a, input logic [31:0] wd);
    int unsigned sh;
    logic [31:0] mask;
    if (size == 2) return wd;
    if (size == 0) begin sh = 8 * (a % 4);  mask = 32'hFF << sh;   end
    else           begin sh = 16 * ((a % 4) / 2); mask = 32'hFFFF << sh; end
    return (w & ~mask) | ((wd << sh) & mask);
  endfunction

  function automatic bit model_bad(input int size, input logic [31:0] a);
    return size == 3 || (size == 1 && (a % 2) != 0) || (size == 2 && (a % 4) != 0);
  endfunction

  task automatic run_if(input logic [31:0] a, output int lat, output logic [31:0] rd,
                        output bit tmo, output int ens, output logic pulse2);
    int e0;
    e0 = en_cnt;
    bus.if_addr = a;
    bus.if_req  = 1'b1;
    lat = 0; rd = '0; tmo = 1'b1;
    for (int c = 1; c <= 30; c++) begin
      @(posedge clk); #1;
      if (bus.if_done) begin lat = c; rd = bus.if_rdata; tmo = 1'b0; break; end
    end
    ens = en_cnt - e0;
    bus.if_req = 1'b0;
    @(posedge clk); #1;
    pulse2 = bus.if_done;
  endtask

  task automatic run_ls(input logic we, input logic [1:0] size, input logic sgn,
                        input logic [31:0] a, input logic [31:0] wd,
                        output int lat, output logic [31:0] rd, output logic err,
                        output bit tmo, output int ens, output logic pulse2);
    int e0;
    e0 = en_cnt;
    bus.ls_we = we; bus.ls_size = size; bus.ls_signed = sgn;
    bus.ls_addr = a; bus.ls_wdata = wd;
    bus.ls_req = 1'b1;
    lat = 0; rd = '0; err = 1'b0; tmo = 1'b1;
    for (int c = 1; c <= 30; c++) begin
      @(posedge clk); #1;
      if (bus.ls_done) begin lat = c; rd = bus.ls_rdata; err = bus.ls_err; tmo = 1'b0; break; end
    end
    ens = en_cnt - e0;
    bus.ls_req = 1'b0;
    @(posedge clk); #1;
    pulse2 = bus.ls_done;
  endtask

  task automatic test_reset();
    logic [133:0] outs;
    int lat, ens;
    logic [31:0] rd;
    bit tmo;
    logic p2, seen;
    rst_n = 1'b0;
    #1;
    outs = {bus.if_done, bus.ls_done, bus.ls_err, bus.mem_en, bus.mem_rw, bus.busy,
            bus.if_rdata, bus.ls_rdata, bus.mem_addr, bus.mem_wdata};
    checks++;
    if (outs !== '0) begin errors++; $display("FAIL reset_outputs got %h want 0", outs); end
    repeat (2) @(posedge clk);
    @(negedge clk); rst_n = 1'b1;
    // Start a fetch and pull reset while it waits for read data.
    bus.if_addr = 32'h40; bus.if_req = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b0; bus.if_req = 1'b0;
    #1;
    outs = {bus.if_done, bus.ls_done, bus.ls_err, bus.mem_en, bus.mem_rw, bus.busy,
            bus.if_rdata, bus.ls_rdata, bus.mem_addr, bus.mem_wdata};
    checks++;
    if (outs !== '0) begin errors++; $display("FAIL reset_mid_wait got %h want 0", outs); end
    repeat (2) @(posedge clk);
    @(negedge clk); rst_n = 1'b1;
    seen = 1'b0;
    for (int c = 0; c < 8; c++) begin
      @(posedge clk); #1;
      if (bus.if_done || bus.ls_done || bus.mem_en) seen = 1'b1;
    end
    checks++;
    if (seen !== 1'b0) begin errors++; $display("FAIL reset_no_done got activity=%b want 0", seen); end
    run_if(32'h100, lat, rd, tmo, ens, p2);
    checks++;
    if (tmo || rd !== ref_mem[32'h40]) begin
      errors++; $display("FAIL reset_next_fetch got %h tmo=%0d want %h", rd, tmo, ref_mem[32'h40]);
    end
  endtask

  task automatic test_fetch();
    int lat, ens;
    logic [31:0] rd;
    bit tmo;
    logic p2;
    run_if(32'h40, lat, rd, tmo, ens, p2);
    checks++;
    if (rd !== 32'hDEADBEEF) begin errors++; $display("FAIL fetch_data got %h want deadbeef", rd); end
    checks++;
    if (tmo || lat != int'(MEM_LAT) + 2) begin
      errors++; $display("FAIL fetch_latency got %0d tmo=%0d want %0d", lat, tmo, MEM_LAT + 2);
    end
    checks++;
    if (ens != 1 || last_rd_addr !== 32'h40) begin
      errors++; $display("FAIL fetch_access got %0d strobes at %h want 1 at 40", ens, last_rd_addr);
    end
    checks++;
    if (p2 !== 1'b0) begin errors++; $display("FAIL fetch_pulse got done=%b next cycle want 0", p2); end
    run_if(32'h43, lat, rd, tmo, ens, p2);
    checks++;
    if (tmo || rd !== ref_mem[32'h10] || last_rd_addr !== 32'h40) begin
      errors++; $display("FAIL fetch_unaligned got %h at %h want %h at 40", rd, last_rd_addr, ref_mem[32'h10]);
    end
  endtask

  task automatic test_load_byte();
    int lat, ens;
    logic [31:0] rd, want;
    logic err, p2;
    bit tmo;
    want = model_load(ref_mem[32'h40], 0, 1'b1, 32'h103);
    run_ls(1'b0, 2'b00, 1'b1, 32'h103, '0, lat, rd, err, tmo, ens, p2);
    checks++;
    if (tmo || rd !== want || want !== 32'hFFFFFF80 || err !== 1'b0) begin
      errors++; $display("FAIL load_byte_signed got %h err=%b want ffffff80", rd, err);
    end
    checks++;
    if (lat != int'(MEM_LAT) + 2 || p2 !== 1'b0) begin
      errors++; $display("FAIL load_latency got %0d pulse2=%b want %0d", lat, p2, MEM_LAT + 2);
    end
    run_ls(1'b0, 2'b00, 1'b0, 32'h103, '0, lat, rd, err, tmo, ens, p2);
    checks++;
    if (tmo || rd !== 32'h00000080) begin errors++; $display("FAIL load_byte_unsigned got %h want 00000080", rd); end
  endtask

  task automatic test_store_half();
    int lat, ens;
    logic [31:0] rd, want;
    logic err, p2;
    bit tmo;
    want = model_store(ref_mem[32'h80], 1, 32'h202, 32'h0000ABCD);
    run_ls(1'b1, 2'b01, 1'b0, 32'h202, 32'h0000ABCD, lat, rd, err, tmo, ens, p2);
    ref_mem[32'h80] = want;
    checks++;
    if (ram_word(32'h200) !== 32'hABCD3344 || want !== 32'hABCD3344) begin
      errors++; $display("FAIL store_half_data got %h want abcd3344", ram_word(32'h200));
    end
    checks++;
    if (tmo || lat != int'(MEM_LAT) + 3 || ens != 2 || last_wr_addr !== 32'h200) begin
      errors++; $display("FAIL store_half_access got lat=%0d strobes=%0d wr=%h want %0d 2 200",
                         lat, ens, last_wr_addr, MEM_LAT + 3);
    end
  endtask

  task automatic test_store_err();
    int lat, ens;
    logic [31:0] rd;
    logic err, p2;
    bit tmo;
    run_ls(1'b1, 2'b10, 1'b0, 32'h105, 32'h12345678, lat, rd, err, tmo, ens, p2);
    checks++;
    if (tmo || lat != 1 || err !== 1'b1 || ens != 0) begin
      errors++; $display("FAIL store_misaligned got lat=%0d err=%b strobes=%0d want 1 1 0", lat, err, ens);
    end
    run_ls(1'b0, 2'b11, 1'b1, 32'h100, '0, lat, rd, err, tmo, ens, p2);
    checks++;
    if (tmo || lat != 1 || err !== 1'b1 || ens != 0 || rd !== '0) begin
      errors++; $display("FAIL illegal_size got lat=%0d err=%b strobes=%0d rd=%h want 1 1 0 0", lat, err, ens, rd);
    end
  endtask

  task automatic test_back_to_back();
    int order[$];
    logic prev_if, prev_ls, bad_pulse, bad_data;
    logic [31:0] want;
    rst_n = 1'b0;
    bus.if_addr = 32'h40; bus.if_req = 1'b1;
    bus.ls_we = 1'b0; bus.ls_size = 2'b10; bus.ls_signed = 1'b0;
    bus.ls_addr = 32'h104; bus.ls_wdata = '0; bus.ls_req = 1'b1;
    want = model_load(ref_mem[32'h41], 2, 1'b0, 32'h104);
    repeat (2) @(posedge clk);
    @(negedge clk); rst_n = 1'b1;
    prev_if = 1'b0; prev_ls = 1'b0; bad_pulse = 1'b0; bad_data = 1'b0;
    for (int c = 0; c < 60 && order.size() < 4; c++) begin
      @(posedge clk); #1;
      if ((bus.if_done && bus.ls_done) || (bus.if_done && prev_if) || (bus.ls_done && prev_ls)) bad_pulse = 1'b1;
      if (bus.ls_done && bus.ls_rdata !== want) bad_data = 1'b1;
      if (bus.if_done && bus.if_rdata !== ref_mem[32'h10]) bad_data = 1'b1;
      if (bus.ls_done) order.push_back(1);
      if (bus.if_done) order.push_back(0);
      prev_if = bus.if_done; prev_ls = bus.ls_done;
    end
    bus.if_req = 1'b0; bus.ls_req = 1'b0;
    checks++;
    if (order.size() != 4 || order[0] != 1 || order[1] != 0 || order[2] != 1 || order[3] != 0) begin
      errors++; $display("FAIL b2b_order got %0d grants %p want LS IF LS IF (1 0 1 0)", order.size(), order);
    end
    checks++;
    if (bad_pulse || bad_data) begin
      errors++; $display("FAIL b2b_pulses got bad_pulse=%b bad_data=%b want 0 0", bad_pulse, bad_data);
    end
    for (int c = 0; c < 10 && bus.busy; c++) begin @(posedge clk); #1; end
    @(posedge clk); #1;
  endtask

  task automatic test_random();
    int lat, ens, kind, size, wlat, wens;
    logic [31:0] a, wd, rd, wrd, old;
    logic we, sgn, err, p2, werr;
    bit tmo, bad;
    for (int n = 0; n < 80; n++) begin
      kind = $urandom_range(0, 2);
      a    = 32'($urandom_range(0, 1023));
      old  = ref_mem[a[9:2]];
      if (kind == 0) begin
        run_if(a, lat, rd, tmo, ens, p2);
        checks++;
        if (tmo || rd !== old || lat != int'(MEM_LAT) + 2 || ens != 1 || p2 !== 1'b0) begin
          errors++; $display("FAIL rnd_fetch a=%h got %h lat=%0d en=%0d want %h lat=%0d en=1", a, rd, lat, ens, old, MEM_LAT + 2);
        end
      end else begin
        we   = logic'(kind == 2);
        size = $urandom_range(0, 3);
        sgn  = logic'($urandom_range(0, 1));
        wd   = $urandom;
        bad  = model_bad(size, a);
        if (bad) begin
          wlat = 1; wens = 0; werr = 1'b1; wrd = '0;
        end else if (!we) begin
          wlat = MEM_LAT + 2; wens = 1; werr = 1'b0; wrd = model_load(old, size, sgn, a);
        end else begin
          wlat = (size == 2) ? 2 : MEM_LAT + 3; wens = (size == 2) ? 1 : 2; werr = 1'b0; wrd = '0;
          ref_mem[a[9:2]] = model_store(old, size, a, wd);
        end
        run_ls(we, 2'(size), sgn, a, wd, lat, rd, err, tmo, ens, p2);
        checks++;
        if (tmo || rd !== wrd || err !== werr || lat != wlat || ens != wens || p2 !== 1'b0) begin
          errors++; $display("FAIL rnd_ls we=%b sz=%0d a=%h got rd=%h err=%b lat=%0d en=%0d want %h %b %0d %0d",
                             we, size, a, rd, err, lat, ens, wrd, werr, wlat, wens);
        end
        if (we && !bad) begin
          checks++;
          if (ram_word(a) !== ref_mem[a[9:2]]) begin
            errors++; $display("FAIL rnd_store_mem a=%h got %h want %h", a, ram_word(a), ref_mem[a[9:2]]);
          end
        end
      end
    end
  endtask

  initial begin
    bus.if_req = 1'b0; bus.if_addr = '0;
    bus.ls_req = 1'b0; bus.ls_we = 1'b0; bus.ls_size = 2'b00; bus.ls_signed = 1'b0;
    bus.ls_addr = '0; bus.ls_wdata = '0;
    for (int i = 0; i < 256; i++) ref_mem[i] = mem_init(i);
    test_reset();
    test_fetch();
    test_load_byte();
    test_store_half();
    test_store_err();
    test_back_to_back();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog got timeout want finish");
    $fatal(1);
  end

endmodule
